// File: rtl/match_controller_if.sv
// Match controller bus: raw player inputs in, screen/score outputs back.
//   button_enter, button_pause : raw asynchronous buttons
//   pause_selection            : PAUSE menu choice (0 resume, 1 re-serve, 2 quit, 3 no-op)
//   goal                       : one-cycle point pulses, bit i = player i
//   tick_game, tick_menu       : tick strobes gated by current state
//   state                      : START 0, SERVE 1, PLAY 2, PAUSE 3, OVER 4
//   enable_*                   : one-hot screen selects
//   serve                      : one-cycle ball release
//   scores                     : player i in [i*SCORE_WIDTH +: SCORE_WIDTH]
//   winner                     : one-hot winner, valid in OVER
interface match_controller_if #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned SCORE_WIDTH = 4
);
  logic                              button_enter;
  logic                              button_pause;
  logic [1:0]                        pause_selection;
  logic [NUM_PLAYERS-1:0]            goal;
  logic                              tick_game;
  logic                              tick_menu;
  logic [2:0]                        state;
  logic                              enable_start;
  logic                              enable_game;
  logic                              enable_pause;
  logic                              enable_over;
  logic                              serve;
  logic [NUM_PLAYERS*SCORE_WIDTH-1:0] scores;
  logic [NUM_PLAYERS-1:0]            winner;

  modport master (
    output button_enter, button_pause, pause_selection, goal,
    input  tick_game, tick_menu, state, enable_start, enable_game,
           enable_pause, enable_over, serve, scores, winner
  );

  modport slave (
    input  button_enter, button_pause, pause_selection, goal,
    output tick_game, tick_menu, state, enable_start, enable_game,
           enable_pause, enable_over, serve, scores, winner
  );
endinterface

// File: rtl/match_controller.sv
// Match controller: tick divider, button synchronise/debounce and the
// START/SERVE/PLAY/PAUSE/OVER game FSM with score and winner tracking.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : match_controller_if.slave (buttons, goals, screen/score outputs)
module match_controller #(
  parameter int unsigned NUM_PLAYERS    = 2,
  parameter int unsigned SCORE_WIDTH    = 4,
  parameter int unsigned WIN_SCORE      = 9,
  parameter int unsigned TICK_DIV       = 6000,
  parameter int unsigned DEBOUNCE_TICKS = 200,
  parameter int unsigned SERVE_TICKS    = 60
) (
  input  logic                 clk,
  input  logic                 reset,
  match_controller_if.slave    bus
);

  localparam int unsigned TICK_W  = $clog2(TICK_DIV);
  localparam int unsigned DEB_W   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned SERVE_W = $clog2(SERVE_TICKS + 1);
  localparam int unsigned SC_W    = NUM_PLAYERS * SCORE_WIDTH;

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic                   tick_q, tick_d;
  logic [1:0]             ent_sync_q, pau_sync_q;
  logic [DEB_W-1:0]       ent_hold_q, ent_hold_d, pau_hold_q, pau_hold_d;
  logic                   enter_press, pause_press;
  state_e                 state_q, state_d;
  logic [SERVE_W-1:0]     serve_cnt_q, serve_cnt_d;
  logic [SC_W-1:0]        scores_q, scores_d;
  logic [NUM_PLAYERS-1:0] winner_q, winner_d;
  logic                   serve_q, serve_d;
  logic                   tick_game_q, tick_game_d, tick_menu_q, tick_menu_d;
  logic                   en_start_q, en_start_d, en_game_q, en_game_d;
  logic                   en_pause_q, en_pause_d, en_over_q, en_over_d;
  logic [NUM_PLAYERS-1:0] goal_low;
  logic [SCORE_WIDTH-1:0] goal_score;

  // Hold count saturates at DEBOUNCE_TICKS so a held button re-arms only after a low sample
  function automatic logic [DEB_W-1:0] hold_next(input logic [DEB_W-1:0] h,
                                                 input logic s, input logic t);
    if (!t)                              return h;
    if (!s)                              return '0;
    if (h == DEB_W'(DEBOUNCE_TICKS))     return h;
    return h + DEB_W'(1);
  endfunction

  // Tick divider; tick_q is high while the counter sits at TICK_DIV-1
  always_comb begin
    tick_cnt_d = (tick_cnt_q == TICK_W'(TICK_DIV - 1)) ? '0 : tick_cnt_q + TICK_W'(1);
    tick_d     = (tick_cnt_d == TICK_W'(TICK_DIV - 1));
  end

  // Debounce on synchronised buttons
  always_comb begin
    ent_hold_d  = hold_next(ent_hold_q, ent_sync_q[1], tick_q);
    pau_hold_d  = hold_next(pau_hold_q, pau_sync_q[1], tick_q);
    enter_press = tick_q && ent_sync_q[1] && (ent_hold_q == DEB_W'(DEBOUNCE_TICKS - 1));
    pause_press = tick_q && pau_sync_q[1] && (pau_hold_q == DEB_W'(DEBOUNCE_TICKS - 1));
  end

  // Lowest set goal bit wins the point; goal_score is that player's incremented score
  always_comb begin
    goal_low   = bus.goal & NUM_PLAYERS'(~bus.goal + NUM_PLAYERS'(1));
    goal_score = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (goal_low[i]) goal_score = scores_q[i*SCORE_WIDTH +: SCORE_WIDTH] + SCORE_WIDTH'(1);
    end
  end

  // Game FSM next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    serve_cnt_d = '0;
    scores_d    = scores_q;
    winner_d    = winner_q;
    serve_d     = 1'b0;
    unique case (state_q)
      ST_START: begin
        if (enter_press) begin
          scores_d = '0;
          state_d  = ST_SERVE;
        end
      end
      ST_SERVE: begin
        serve_cnt_d = serve_cnt_q;
        if (tick_q) begin
          if (serve_cnt_q == SERVE_W'(SERVE_TICKS - 1)) begin
            serve_cnt_d = '0;
            serve_d     = 1'b1;
            state_d     = ST_PLAY;
          end else begin
            serve_cnt_d = serve_cnt_q + SERVE_W'(1);
          end
        end
      end
      ST_PLAY: begin
        if (|bus.goal) begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (goal_low[i]) scores_d[i*SCORE_WIDTH +: SCORE_WIDTH] = goal_score;
          end
          if (goal_score == SCORE_WIDTH'(WIN_SCORE)) begin
            winner_d = goal_low;
            state_d  = ST_OVER;
          end else begin
            state_d  = ST_SERVE;
          end
        end else if (pause_press) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (enter_press) begin
          case (bus.pause_selection)
            2'd0:    state_d = ST_PLAY;
            2'd1:    state_d = ST_SERVE;
            2'd2:    state_d = ST_START;
            default: state_d = ST_PAUSE;
          endcase
        end
      end
      ST_OVER: begin
        if (enter_press) begin
          winner_d = '0;
          state_d  = ST_START;
        end
      end
      default: state_d = ST_START;
    endcase

    // Registering against state_d/tick_d lines the strobes up with the current state
    tick_game_d = tick_d && (state_d == ST_PLAY);
    tick_menu_d = tick_d && (state_d == ST_START || state_d == ST_PAUSE || state_d == ST_OVER);
    en_start_d  = (state_d == ST_START);
    en_game_d   = (state_d == ST_SERVE) || (state_d == ST_PLAY);
    en_pause_d  = (state_d == ST_PAUSE);
    en_over_d   = (state_d == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q  <= '0;
      tick_q      <= 1'b0;
      ent_sync_q  <= '0;
      pau_sync_q  <= '0;
      ent_hold_q  <= '0;
      pau_hold_q  <= '0;
      state_q     <= ST_START;
      serve_cnt_q <= '0;
      scores_q    <= '0;
      winner_q    <= '0;
      serve_q     <= 1'b0;
      tick_game_q <= 1'b0;
      tick_menu_q <= 1'b0;
      en_start_q  <= 1'b1;
      en_game_q   <= 1'b0;
      en_pause_q  <= 1'b0;
      en_over_q   <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      tick_q      <= tick_d;
      ent_sync_q  <= {ent_sync_q[0], bus.button_enter};
      pau_sync_q  <= {pau_sync_q[0], bus.button_pause};
      ent_hold_q  <= ent_hold_d;
      pau_hold_q  <= pau_hold_d;
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      scores_q    <= scores_d;
      winner_q    <= winner_d;
      serve_q     <= serve_d;
      tick_game_q <= tick_game_d;
      tick_menu_q <= tick_menu_d;
      en_start_q  <= en_start_d;
      en_game_q   <= en_game_d;
      en_pause_q  <= en_pause_d;
      en_over_q   <= en_over_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.tick_game    = tick_game_q;
  assign bus.tick_menu    = tick_menu_q;
  assign bus.serve        = serve_q;
  assign bus.scores       = scores_q;
  assign bus.winner       = winner_q;
  assign bus.enable_start = en_start_q;
  assign bus.enable_game  = en_game_q;
  assign bus.enable_pause = en_pause_q;
  assign bus.enable_over  = en_over_q;

endmodule

// File: tb/tb_match_controller.sv
// Testbench for match_controller: a transaction-level game model pushes the
// expected state-change records, a monitor pops them on every DUT state change.
module tb_match_controller;
  localparam int unsigned NP = 2, SW = 4, WIN = 2, TDIV = 4, DEB = 2, SRV = 3;
  localparam logic [2:0] S_START = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2,
                         S_PAUSE = 3'd3, S_OVER = 3'd4;

  logic clk, reset;
  match_controller_if #(.NUM_PLAYERS(NP), .SCORE_WIDTH(SW)) bus();

  match_controller #(
    .NUM_PLAYERS(NP), .SCORE_WIDTH(SW), .WIN_SCORE(WIN),
    .TICK_DIV(TDIV), .DEBOUNCE_TICKS(DEB), .SERVE_TICKS(SRV)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic [SW-1:0] s1;
    logic [SW-1:0] s0;
    logic [NP-1:0] win;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned m_score[NP];
  logic [2:0]  m_state;
  logic [NP-1:0] m_win;
  logic [2:0]  prev_state = 3'd0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // ---------------- behavioural game model ----------------
  function automatic void push_ev();
    ev_t e;
    e.st = m_state; e.s0 = SW'(m_score[0]); e.s1 = SW'(m_score[1]); e.win = m_win;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    m_state = S_START; m_win = '0;
    for (int i = 0; i < NP; i++) m_score[i] = 0;
  endfunction

  // Entering SERVE always runs through to PLAY once the serve timer expires
  function automatic void m_to_serve();
    m_state = S_SERVE; push_ev();
    m_state = S_PLAY;  push_ev();
  endfunction

  function automatic void model_goal(input logic [NP-1:0] g);
    if (m_state != S_PLAY || g == '0) return;
    for (int i = 0; i < NP; i++) begin
      if (g[i]) begin
        m_score[i]++;
        if (m_score[i] == WIN) begin
          m_win = NP'(1) << i; m_state = S_OVER; push_ev();
        end else begin
          m_to_serve();
        end
        break;
      end
    end
  endfunction

  function automatic void model_pause();
    if (m_state == S_PLAY) begin m_state = S_PAUSE; push_ev(); end
  endfunction

  function automatic void model_enter(input logic [1:0] sel);
    case (m_state)
      S_START: begin
        for (int i = 0; i < NP; i++) m_score[i] = 0;
        m_to_serve();
      end
      S_PAUSE: begin
        case (sel)
          2'd0: begin m_state = S_PLAY; push_ev(); end
          2'd1: m_to_serve();
          2'd2: begin m_state = S_START; push_ev(); end
          default: ;
        endcase
      end
      S_OVER: begin m_win = '0; m_state = S_START; push_ev(); end
      default: ;
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    ev_t e;
    logic [3:0] en_exp;
    forever begin
      @(negedge clk);
      if (bus.tick_game) chk("tick_game_only_in_play", int'(bus.state), int'(S_PLAY));
      if (bus.tick_menu) begin
        checks++;
        if (!(bus.state == S_START || bus.state == S_PAUSE || bus.state == S_OVER)) begin
          failures++;
          $display("FAIL tick_menu_state got_state=%0d exp=menu_state", bus.state);
        end
      end
      if (bus.serve) begin
        checks++;
        if (!(bus.state == S_PLAY && prev_state == S_SERVE)) begin
          failures++;
          $display("FAIL serve_pulse state=%0d prev=%0d exp=PLAY_from_SERVE", bus.state, prev_state);
        end
      end
      if (bus.state != prev_state) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_transition got_state=%0d exp=none", bus.state);
        end else begin
          e = exp_q.pop_front();
          if (bus.state != e.st || bus.scores != {e.s1, e.s0} || bus.winner != e.win) begin
            failures++;
            $display("FAIL transition got st=%0d sc=%h win=%b exp st=%0d sc=%h win=%b",
                     bus.state, bus.scores, bus.winner, e.st, {e.s1, e.s0}, e.win);
          end
        end
        en_exp = {bus.state == S_START, bus.state == S_SERVE || bus.state == S_PLAY,
                  bus.state == S_PAUSE, bus.state == S_OVER};
        chk("enables", int'({bus.enable_start, bus.enable_game, bus.enable_pause, bus.enable_over}),
            int'(en_exp));
      end
      prev_state = bus.state;
    end
  end

  // ---------------- stimulus helpers (start and end on a negedge) ----------------
  task automatic wait_state(input logic [2:0] st, input string name);
    int n = 0;
    while (bus.state != st && n < 200) begin @(negedge clk); n++; end
    chk(name, int'(bus.state), int'(st));
  endtask

  task automatic sync_tick(input bit game);
    int n = 0;
    while (!(game ? bus.tick_game : bus.tick_menu) && n < 40) begin @(negedge clk); n++; end
    chk("tick_sync", int'(game ? bus.tick_game : bus.tick_menu), 1);
  endtask

  task automatic press_enter(input logic [1:0] sel, input int hold);
    bus.pause_selection = sel;
    model_enter(sel);
    bus.button_enter = 1'b1;
    repeat (hold) @(negedge clk);
    bus.button_enter = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic press_pause();
    model_pause();
    bus.button_pause = 1'b1;
    repeat (16) @(negedge clk);
    bus.button_pause = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic pulse_goal(input logic [NP-1:0] g);
    bus.goal = g;
    @(negedge clk);
    bus.goal = '0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog_timeout sim did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin : stim
    int n, cnt;
    logic [NP-1:0] g;
    logic [1:0] sel;
    int r;
    reset = 1'b1;
    bus.button_enter = 1'b0; bus.button_pause = 1'b0;
    bus.pause_selection = 2'd0; bus.goal = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_state", int'(bus.state), int'(S_START));
    chk("rst_scores", int'(bus.scores), 0);
    chk("rst_winner", int'(bus.winner), 0);
    chk("rst_serve", int'(bus.serve), 0);
    chk("rst_ticks", int'({bus.tick_game, bus.tick_menu}), 0);
    chk("rst_enables", int'({bus.enable_start, bus.enable_game, bus.enable_pause, bus.enable_over}), 8);
    reset = 1'b0;
    @(negedge clk);

    // Enter held from START: press on the 2nd tick, serve 3 ticks later
    sync_tick(1'b0);
    model_enter(2'd0);
    bus.button_enter = 1'b1;
    n = 0; cnt = 0;
    while (cnt < 2 && n < 40) begin @(negedge clk); n++; if (bus.tick_menu) cnt++; end
    chk("start_before_press", int'(bus.state), int'(S_START));
    @(negedge clk);
    chk("serve_after_press", int'(bus.state), int'(S_SERVE));
    chk("scores_cleared", int'(bus.scores), 0);
    n = 0;
    while (!bus.serve && n < 40) begin @(negedge clk); n++; end
    chk("serve_latency", n, 12);
    chk("play_at_serve", int'(bus.state), int'(S_PLAY));
    bus.button_enter = 1'b0;
    repeat (12) @(negedge clk);

    // Simultaneous goals: lowest index scores; goals in SERVE ignored; then win
    model_goal(2'b11); pulse_goal(2'b11);
    chk("goal11_state", int'(bus.state), int'(S_SERVE));
    chk("goal11_scores", int'(bus.scores), 8'h01);
    pulse_goal(2'b11);
    wait_state(S_PLAY, "wait_play_1");
    model_goal(2'b01); pulse_goal(2'b01);
    chk("win_state", int'(bus.state), int'(S_OVER));
    chk("win_winner", int'(bus.winner), 2'b01);
    chk("win_score_p0", int'(bus.scores[3:0]), 2);

    // Long hold in OVER: one press only (START, not on to SERVE)
    press_enter(2'd0, 40);
    chk("long_hold_single_press", int'(bus.state), int'(S_START));

    // One-sample glitch in START: no press
    sync_tick(1'b0);
    bus.button_enter = 1'b1;
    @(negedge clk);
    sync_tick(1'b0);
    bus.button_enter = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_no_press", int'(bus.state), int'(S_START));

    // Goal and pause press in the same cycle: goal wins
    press_enter(2'd0, 16);
    wait_state(S_PLAY, "wait_play_2");
    sync_tick(1'b1);
    model_goal(2'b10);
    bus.button_pause = 1'b1;
    n = 0; cnt = 0;
    while (cnt < 2 && n < 40) begin @(negedge clk); n++; if (bus.tick_game) cnt++; end
    bus.goal = 2'b10;
    @(negedge clk);
    bus.goal = '0;
    chk("goal_pause_state", int'(bus.state), int'(S_SERVE));
    bus.button_pause = 1'b0;
    repeat (12) @(negedge clk);
    wait_state(S_PLAY, "wait_play_3");
    chk("goal_pause_scores", int'(bus.scores), 8'h10);

    // PAUSE menu selections 3, 1, 2
    press_pause();
    wait_state(S_PAUSE, "wait_pause_1");
    press_enter(2'd3, 16);
    chk("pause_sel3_stays", int'(bus.state), int'(S_PAUSE));
    press_enter(2'd1, 16);
    wait_state(S_PLAY, "wait_play_4");
    chk("reserve_scores_kept", int'(bus.scores), 8'h10);
    press_pause();
    wait_state(S_PAUSE, "wait_pause_2");
    press_enter(2'd2, 16);
    wait_state(S_START, "pause_quit");

    // Reset in PLAY with player 0 at 1
    press_enter(2'd0, 16);
    wait_state(S_PLAY, "wait_play_5");
    model_goal(2'b01); pulse_goal(2'b01);
    wait_state(S_PLAY, "wait_play_6");
    chk("pre_reset_scores", int'(bus.scores), 8'h01);
    model_reset(); push_ev();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_state", int'(bus.state), int'(S_START));
    chk("midreset_scores", int'(bus.scores), 0);
    chk("midreset_enable_start", int'(bus.enable_start), 1);
    repeat (20) @(negedge clk);

    // Randomised play against the model
    for (int it = 0; it < 60; it++) begin
      case (m_state)
        S_START: begin
          press_enter(2'($urandom_range(0, 3)), 16);
          wait_state(S_PLAY, "rnd_start_play");
        end
        S_PLAY: begin
          r = int'($urandom_range(0, 4));
          if (r <= 2) begin
            g = NP'($urandom_range(0, 3));
            model_goal(g);
            pulse_goal(g);
            if (g != '0) begin
              if (m_state == S_OVER) wait_state(S_OVER, "rnd_over");
              else begin
                pulse_goal(NP'($urandom_range(1, 3)));
                wait_state(S_PLAY, "rnd_reserve");
              end
            end
          end else if (r == 3) begin
            press_pause();
            wait_state(S_PAUSE, "rnd_pause");
          end else begin
            press_enter(2'($urandom_range(0, 3)), 16);
            chk("rnd_enter_in_play", int'(bus.state), int'(S_PLAY));
          end
        end
        S_PAUSE: begin
          pulse_goal(NP'($urandom_range(1, 3)));
          sel = 2'($urandom_range(0, 3));
          press_enter(sel, 16);
          wait_state(m_state, "rnd_pause_menu");
        end
        default: begin
          press_enter(2'd0, 16);
          wait_state(S_START, "rnd_over_exit");
        end
      endcase
    end

    repeat (20) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
